multicycle_ctrl_fsm: RTL and testbench

- Parametrised main control FSM for the multicycle ARM-subset processor. It drives the datapath mux selects, the write enables and ALUOp for each instruction phase.
- Compared with the current controller it adds:
  - memory wait-state handshake (MemReady) with a timeout fault;
  - write-back skip for flag-only data-processing ops;
  - a wider ALUOp field.
- Sits between the instruction register (Op/Funct) and the datapath, next to the ALU decoder and the condition logic.

---
 rtl/multicycle_ctrl_fsm_if.sv | 39 +++
 rtl/multicycle_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - control bundle between instruction register, main FSM and datapath
//
// Purpose : groups the decode inputs (Op/Funct), the memory handshake (MemReady)
//           and every datapath control the main FSM drives.
// Modports: master - the control FSM (reads Op/Funct/MemReady, drives controls)
//           slave  - the datapath / instruction register side
// Params  : ALUOP_W - width of ALUOp
interface multicycle_ctrl_fsm_if #(
    parameter int ALUOP_W = 2
);
    logic [1:0]         Op;
    logic [5:0]         Funct;
    logic               MemReady;
    logic               IRWrite;
    logic               AdrSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ResultSrc;
    logic               NextPC;
    logic               RegW;
    logic               MemW;
    logic               Branch;
    logic [ALUOP_W-1:0] ALUOp;
    logic               LinkW;
    logic               Fault;
    logic [3:0]         StateDbg;

    modport master (
        input  Op, Funct, MemReady,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, LinkW, Fault, StateDbg
    );

    modport slave (
        output Op, Funct, MemReady,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC,
               RegW, MemW, Branch, ALUOp, LinkW, Fault, StateDbg
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - main control FSM of the multicycle ARM-subset processor
//
// Purpose : sequences FETCH/DECODE/EXECUTE/MEMORY/WRITE-BACK phases, waits on
//           MemReady in memory phases with a timeout into a sticky FAULT state,
//           and skips write-back for flag-only data-processing ops.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-low reset
//           bus   - multicycle_ctrl_fsm_if.master (Op, Funct, MemReady in;
//                   datapath controls, Fault, StateDbg out)
// Params  : ALUOP_W (>=1), MEM_TIMEOUT (>=1), TMO_W (2**TMO_W > MEM_TIMEOUT)
// Option  : `define MULTICYCLE_CTRL_BL_EN enables the BRLINK (branch-with-link) state.
module multicycle_ctrl_fsm #(
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_ctrl_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        FAULT    = 4'd10,
        BRLINK   = 4'd11
    } state_e;

    state_e             state_q, state_d;
    logic [TMO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               fault_q, fault_d;

    logic               in_wait;
    logic               timeout;
    logic [TMO_W-1:0]   wait_inc;
    logic               flag_only;
    logic [ALUOP_W-1:0] alu_op_exec;

    // TST/TEQ/CMP/CMN only update flags, so they bypass ALUWB.
    assign flag_only = (bus.Funct[4:3] == 2'b10);
    assign wait_inc  = wait_cnt_q + TMO_W'(1);
    assign timeout   = (wait_inc == TMO_W'(MEM_TIMEOUT));

    // Execute-phase ALUOp: bit 0 selects DP decode, bit 1 marks the flag-only
    // class when the field is wide enough; higher bits stay 0.
    always_comb begin
        alu_op_exec    = '0;
        alu_op_exec[0] = 1'b1;
        for (int i = 1; i < ALUOP_W; i++) begin
            alu_op_exec[i] = (i == 1) && flag_only;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
        end
    end

    // Next state, wait counter and sticky fault.
    always_comb begin
        state_d = state_q;
        in_wait = 1'b0;
        case (state_q)
            FETCH: begin
                in_wait = 1'b1;
                if (bus.MemReady) state_d = DECODE;
            end
            DECODE: begin
                case (bus.Op)
                    2'b00:   state_d = bus.Funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FAULT;
                endcase
            end
            EXECUTER,
            EXECUTEI: state_d = flag_only ? FETCH : ALUWB;
            MEMADR:   state_d = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                in_wait = 1'b1;
                if (bus.MemReady) state_d = MEMWB;
            end
            MEMWRITE: begin
                in_wait = 1'b1;
                if (bus.MemReady) state_d = FETCH;
            end
            ALUWB:    state_d = FETCH;
            MEMWB:    state_d = FETCH;
`ifdef MULTICYCLE_CTRL_BL_EN
            BRANCH:   state_d = bus.Funct[4] ? BRLINK : FETCH;
            BRLINK:   state_d = FETCH;
`else
            BRANCH:   state_d = FETCH;
`endif
            FAULT:    state_d = FAULT;
            default:  state_d = FAULT;
        endcase

        // A completing access in the timeout cycle still wins.
        if (in_wait && !bus.MemReady && timeout) state_d = FAULT;

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (in_wait && !bus.MemReady) begin
            wait_cnt_d = wait_inc;
        end else begin
            wait_cnt_d = '0;
        end

        fault_d = fault_q | (state_d == FAULT);
    end

    // Moore outputs; only IRWrite/NextPC in FETCH follow MemReady.
    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.NextPC    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.Branch    = 1'b0;
        bus.ALUOp     = '0;
        bus.LinkW     = 1'b0;
        case (state_q)
            FETCH: begin
                bus.IRWrite   = bus.MemReady;
                bus.NextPC    = bus.MemReady;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            DECODE: begin
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
            end
            EXECUTER: bus.ALUOp = alu_op_exec;
            EXECUTEI: begin
                bus.ALUSrcB = 2'b01;
                bus.ALUOp   = alu_op_exec;
            end
            ALUWB:    bus.RegW = 1'b1;
            MEMADR:   bus.ALUSrcB = 2'b01;
            MEMREAD:  bus.AdrSrc = 1'b1;
            MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                bus.MemW   = 1'b1;
            end
            MEMWB: begin
                bus.RegW      = 1'b1;
                bus.ResultSrc = 2'b01;
            end
            BRANCH: begin
                bus.Branch    = 1'b1;
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
            end
`ifdef MULTICYCLE_CTRL_BL_EN
            BRLINK: begin
                bus.LinkW     = 1'b1;
                bus.RegW      = 1'b1;
                bus.ResultSrc = 2'b10;
                bus.ALUSrcA   = 2'b01;
                bus.ALUSrcB   = 2'b10;
            end
`endif
            default: ;
        endcase
    end

    assign bus.Fault    = fault_q;
    assign bus.StateDbg = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

    localparam int TMO = 15;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
                           S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5,
                           S_EXR = 4'd6, S_EXI = 4'd7, S_ALUWB = 4'd8,
                           S_BRANCH = 4'd9, S_FAULT = 4'd10, S_BRLINK = 4'd11;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    multicycle_ctrl_fsm_if #(.ALUOP_W(2)) bus ();

    multicycle_ctrl_fsm #(.ALUOP_W(2), .MEM_TIMEOUT(TMO), .TMO_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [15:0] mr;   // MemReady for cycle i
        int          len;
        logic [63:0] seq;  // expected state for cycle i in nibble i
    } vec_t;

    vec_t vecs[$];

    // Expected control word for a state, from the output table.
    function automatic logic [19:0] spec_ctrl(input logic [3:0] st, input logic [5:0] f,
                                              input logic mr);
        logic irw = 0, adr = 0, npc = 0, regw = 0, memw = 0, br = 0, lnk = 0, flt = 0;
        logic [1:0] sa = 0, sb = 0, rs = 0, aop = 0;
        case (st)
            S_FETCH:    begin irw = mr; npc = mr; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            S_DECODE:   begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
            S_EXR:      aop = {f[4:3] == 2'b10, 1'b1};
            S_EXI:      begin sb = 2'b01; aop = {f[4:3] == 2'b10, 1'b1}; end
            S_ALUWB:    regw = 1;
            S_MEMADR:   sb = 2'b01;
            S_MEMREAD:  adr = 1;
            S_MEMWRITE: begin adr = 1; memw = 1; end
            S_MEMWB:    begin regw = 1; rs = 2'b01; end
            S_BRANCH:   begin br = 1; sb = 2'b01; rs = 2'b10; end
            S_BRLINK:   begin lnk = 1; regw = 1; rs = 2'b10; sa = 2'b01; sb = 2'b10; end
            S_FAULT:    flt = 1;
            default: ;
        endcase
        return {irw, adr, sa, sb, rs, npc, regw, memw, br, aop, lnk, flt, st};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic [3:0] st);
        logic [19:0] exp_v, act_v;
        #1;
        exp_v = spec_ctrl(st, bus.Funct, bus.MemReady);
        act_v = {bus.IRWrite, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc,
                 bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.ALUOp, bus.LinkW,
                 bus.Fault, bus.StateDbg};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s t=%0t: got ctrl=%05h (state %0d) want ctrl=%05h (state %0d)",
                     name, $time, act_v, act_v[3:0], exp_v, st);
        end
    endtask

    // Reset pulse spanning one clock edge; reset state is checked while held.
    task automatic do_reset(input string name);
        reset        = 1'b0;
        bus.MemReady = 1'($urandom_range(0, 1));
        check_now(name, S_FETCH);
        tick();
        reset = 1'b1;
    endtask

    task automatic step(input string name, input logic [3:0] st, input logic mr);
        bus.MemReady = mr;
        check_now(name, st);
        tick();
    endtask

    function automatic vec_t mk(input string n, input logic [1:0] op, input logic [5:0] f,
                                input logic [15:0] mr, input int len, input logic [63:0] seq);
        vec_t v;
        v.name = n; v.op = op; v.funct = f; v.mr = mr; v.len = len; v.seq = seq;
        return v;
    endfunction

    // Random memory-ready pattern: mostly coin flips, sometimes a long stall.
    bit long_mode;
    int stall_len;
    int stall_k;

    function automatic logic pick_mr();
        if (long_mode) begin
            stall_k++;
            return (stall_k > stall_len);
        end
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic new_wait_mode();
        long_mode = ($urandom_range(0, 5) == 0);
        stall_len = $urandom_range(12, 17);
        stall_k   = 0;
    endtask

    // Wait phase: stays in st until MemReady; MEM_TIMEOUT idle cycles -> FAULT.
    task automatic wait_phase(input logic [3:0] st, output bit timed_out);
        int zeros = 0;
        logic mr;
        timed_out = 0;
        new_wait_mode();
        forever begin
            mr = pick_mr();
            step("rand_wait", st, mr);
            if (mr) break;
            zeros++;
            if (zeros == TMO) begin
                timed_out = 1;
                break;
            end
        end
    endtask

    task automatic fault_phase();
        step("rand_fault", S_FAULT, 1'($urandom_range(0, 1)));
        step("rand_fault", S_FAULT, 1'($urandom_range(0, 1)));
        do_reset("rand_reset");
    endtask

    // Reference model: walks one instruction through its phases.
    task automatic run_random_instr();
        logic [1:0] op;
        logic [5:0] f;
        bit to;
        logic [3:0] ex;
        op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        f  = 6'($urandom);
        bus.Op = op; bus.Funct = f;
        wait_phase(S_FETCH, to);
        if (to) begin fault_phase(); return; end
        step("rand_dec", S_DECODE, 1'($urandom_range(0, 1)));
        case (op)
            2'b00: begin
                ex = f[5] ? S_EXI : S_EXR;
                step("rand_ex", ex, 1'($urandom_range(0, 1)));
                if (f[4:3] != 2'b10) step("rand_aluwb", S_ALUWB, 1'($urandom_range(0, 1)));
            end
            2'b01: begin
                step("rand_memadr", S_MEMADR, 1'($urandom_range(0, 1)));
                wait_phase(f[0] ? S_MEMREAD : S_MEMWRITE, to);
                if (to) begin fault_phase(); return; end
                if (f[0]) step("rand_memwb", S_MEMWB, 1'($urandom_range(0, 1)));
            end
            2'b10: begin
                step("rand_branch", S_BRANCH, 1'($urandom_range(0, 1)));
`ifdef MULTICYCLE_CTRL_BL_EN
                if (f[4]) step("rand_brlink", S_BRLINK, 1'($urandom_range(0, 1)));
`endif
            end
            default: fault_phase();
        endcase
    endtask

    initial begin
        reset = 1'b0;
        bus.Op = 2'b00; bus.Funct = 6'b0; bus.MemReady = 1'b0;

        vecs.push_back(mk("add_reg",   2'b00, 6'b001000, 16'h000F, 5, 64'h08610));
        vecs.push_back(mk("cmp_imm",   2'b00, 6'b110101, 16'h0007, 4, 64'h0710));
        vecs.push_back(mk("ldr_wait3", 2'b01, 6'b000001, 16'h00C7, 9, 64'h043333210));
        vecs.push_back(mk("str",       2'b01, 6'b000000, 16'h000F, 5, 64'h05210));
        vecs.push_back(mk("str_wait2", 2'b01, 6'b000000, 16'h0027, 7, 64'h0555210));
        vecs.push_back(mk("b",         2'b10, 6'b000000, 16'h0007, 4, 64'h0910));
`ifdef MULTICYCLE_CTRL_BL_EN
        vecs.push_back(mk("bl",        2'b10, 6'b010000, 16'h000F, 5, 64'h0B910));
`else
        vecs.push_back(mk("bl",        2'b10, 6'b010000, 16'h0007, 4, 64'h0910));
`endif
        vecs.push_back(mk("tst_reg",   2'b00, 6'b010001, 16'h0007, 4, 64'h0610));
        vecs.push_back(mk("mov_imm",   2'b00, 6'b111010, 16'h000F, 5, 64'h08710));
        vecs.push_back(mk("fetch_wait",2'b00, 6'b001000, 16'h003C, 7, 64'h0861000));

        // Reset state with both MemReady values while reset is held.
        #2;
        bus.MemReady = 1'b0; check_now("reset_mr0", S_FETCH);
        bus.MemReady = 1'b1; check_now("reset_mr1", S_FETCH);
        tick();
        reset = 1'b1;

        foreach (vecs[k]) begin
            bus.Op = vecs[k].op; bus.Funct = vecs[k].funct;
            for (int i = 0; i < vecs[k].len; i++) begin
                step(vecs[k].name, vecs[k].seq[i*4 +: 4], vecs[k].mr[i]);
            end
        end

        // STR with MemReady stuck low: 15 MemW cycles, then sticky FAULT.
        bus.Op = 2'b01; bus.Funct = 6'b000000;
        step("str_to_fetch", S_FETCH, 1'b1);
        step("str_to_dec", S_DECODE, 1'b1);
        step("str_to_adr", S_MEMADR, 1'b0);
        for (int i = 0; i < TMO; i++) step("str_to_wait", S_MEMWRITE, 1'b0);
        for (int i = 0; i < 3; i++) step("str_to_fault", S_FAULT, 1'b1);
        do_reset("str_to_reset");

        // LDR completing exactly in the timeout cycle goes on normally.
        bus.Op = 2'b01; bus.Funct = 6'b000001;
        step("ldr_edge_fetch", S_FETCH, 1'b1);
        step("ldr_edge_dec", S_DECODE, 1'b0);
        step("ldr_edge_adr", S_MEMADR, 1'b0);
        for (int i = 0; i < TMO - 1; i++) step("ldr_edge_wait", S_MEMREAD, 1'b0);
        step("ldr_edge_last", S_MEMREAD, 1'b1);
        step("ldr_edge_wb", S_MEMWB, 1'b0);

        // FETCH timeout.
        for (int i = 0; i < TMO; i++) step("fetch_to_wait", S_FETCH, 1'b0);
        step("fetch_to_fault", S_FAULT, 1'b1);
        do_reset("fetch_to_reset");

        // Undefined Op=11 at DECODE.
        bus.Op = 2'b11; bus.Funct = 6'b111111;
        step("op11_fetch", S_FETCH, 1'b1);
        step("op11_dec", S_DECODE, 1'b1);
        step("op11_fault", S_FAULT, 1'b1);
        do_reset("op11_reset");

        // Reset pulsed during MEMWRITE drops MemW immediately.
        bus.Op = 2'b01; bus.Funct = 6'b000000;
        step("rst_mw_fetch", S_FETCH, 1'b1);
        step("rst_mw_dec", S_DECODE, 1'b1);
        step("rst_mw_adr", S_MEMADR, 1'b0);
        bus.MemReady = 1'b0;
        check_now("rst_mw_write", S_MEMWRITE);
        reset = 1'b0;
        check_now("rst_mw_async", S_FETCH);
        tick();
        reset = 1'b1;

        for (int n = 0; n < 400; n++) run_random_instr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
